// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: CPU register bus plus tristate-buffer lines of io_port_ctrl.
//  wr_en/addr/wdata : CPU write strobe, register select, write data
//  rdata/busy       : CPU read data (combinational from addr), turnaround flag
//  pin_dir/pin_dout : buffer dir (1 = drive PIN) and dataW
//  pin_din          : buffer dataR, asynchronous to clk
// modport slave is the controller; modport master is its environment (CPU + buffer).
interface io_port_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             wr_en;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             pin_dir;
    logic [WIDTH-1:0] pin_dout;
    logic [WIDTH-1:0] pin_din;

    modport master (
        output wr_en, addr, wdata, pin_din,
        input  rdata, busy, pin_dir, pin_dout
    );

    modport slave (
        input  wr_en, addr, wdata, pin_din,
        output rdata, busy, pin_dir, pin_dout
    );
endinterface

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped controller for a WIDTH-bit tristate I/O buffer.
// Sequences direction changes with a turnaround gap so the FPGA and the external
// device never drive PIN together, synchronises pin_din and latches per-bit
// change flags while the port is an input.
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  bus        : io_port_ctrl_if.slave (CPU register bus + buffer lines)
// Register map: 0 DATA, 1 DIR, 2 CHG (write-1-to-clear), 3 DOUT (read only).
module io_port_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    io_port_ctrl_if.slave bus
);
    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_DIR  = 2'd1;
    localparam logic [1:0]  ADDR_CHG  = 2'd2;
    localparam logic [1:0]  ADDR_DOUT = 2'd3;

    // TO_IN also covers the synchroniser so din_sync holds only post-release data.
    localparam int unsigned TIN_CYCLES = TURN_CYCLES + SYNC_STAGES;
    localparam int unsigned CNT_W      = $clog2(TIN_CYCLES + 1);
    localparam int unsigned TOUT_LOAD  = (TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1;
    localparam int unsigned TIN_LOAD   = TIN_CYCLES - 1;

    typedef enum logic [1:0] {
        IN_IDLE  = 2'd0,
        TO_OUT   = 2'd1,
        OUT_IDLE = 2'd2,
        TO_IN    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pin_dir_q, pin_dir_d;
    logic             busy_q, busy_d;

    logic             dir_req_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] din_sync_c;
    logic [WIDTH-1:0] din_prev_q;
    logic [WIDTH-1:0] chg_q, chg_d;

    logic             data_wr_c;
    logic             dir_wr_c;
    logic             chg_wr_c;

    // Register write decode; DIR writes are dropped while a turnaround runs.
    assign data_wr_c = bus.wr_en && (bus.addr == ADDR_DATA);
    assign dir_wr_c  = bus.wr_en && (bus.addr == ADDR_DIR) && !busy_q;
    assign chg_wr_c  = bus.wr_en && (bus.addr == ADDR_CHG);

    assign din_sync_c = sync_q[SYNC_STAGES-1];

    // FSM state register together with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IN_IDLE;
            cnt_q     <= '0;
            pin_dir_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pin_dir_q <= pin_dir_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; the counter measures the remaining turnaround cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IN_IDLE: begin
                if (dir_wr_c && bus.wdata[0]) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = OUT_IDLE;
                    end else begin
                        state_d = TO_OUT;
                        cnt_d   = CNT_W'(TOUT_LOAD);
                    end
                end
            end
            TO_OUT: begin
                if (cnt_q == '0) begin
                    state_d = OUT_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT_IDLE: begin
                if (dir_wr_c && !bus.wdata[0]) begin
                    state_d = TO_IN;
                    cnt_d   = CNT_W'(TIN_LOAD);
                end
            end
            TO_IN: begin
                if (cnt_q == '0) begin
                    state_d = IN_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so pin_dir/busy come straight off flops.
    // Release takes effect the cycle after the write; drive only after the gap.
    always_comb begin
        pin_dir_d = 1'b0;
        busy_d    = 1'b0;
        unique case (state_d)
            TO_OUT, TO_IN: busy_d    = 1'b1;
            OUT_IDLE:      pin_dir_d = 1'b1;
            default:       ;
        endcase
    end

    // Change flags: set only while an idle input, W1C otherwise; set beats clear.
    always_comb begin
        logic [WIDTH-1:0] set_c;
        logic [WIDTH-1:0] clr_c;
        set_c = '0;
        clr_c = '0;
        if (state_q == IN_IDLE) begin
            set_c = din_sync_c ^ din_prev_q;
        end
        if (chg_wr_c) begin
            clr_c = bus.wdata;
        end
        chg_d = (chg_q & ~clr_c) | set_c;
    end

    // Data path registers: output data, requested direction, synchroniser, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dir_req_q  <= 1'b0;
            din_prev_q <= '0;
            chg_q      <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            if (data_wr_c) begin
                dout_q <= bus.wdata;
            end
            if (dir_wr_c) begin
                dir_req_q <= bus.wdata[0];
            end
            sync_q[0] <= bus.pin_din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            // Reloaded every cycle so re-entering IN_IDLE never sees a stale edge.
            din_prev_q <= din_sync_c;
            chg_q      <= chg_d;
        end
    end

    // CPU read mux, combinational from addr.
    always_comb begin
        bus.rdata = '0;
        unique case (bus.addr)
            ADDR_DATA: bus.rdata = din_sync_c;
            ADDR_DIR:  bus.rdata = {{(WIDTH-1){1'b0}}, dir_req_q};
            ADDR_CHG:  bus.rdata = chg_q;
            ADDR_DOUT: bus.rdata = dout_q;
            default:   bus.rdata = '0;
        endcase
    end

    assign bus.pin_dir  = pin_dir_q;
    assign bus.busy     = busy_q;
    assign bus.pin_dout = dout_q;

endmodule
